// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for a 5-stage MIPS32 pipeline.
// Merges ID/EX stall requests and flush requests into a per-stage hold
// vector, a registered one-cycle flush pulse with redirect PC, and a
// sticky watchdog flag for runaway EX stalls.
// Optional build macro PIPE_CTRL_PERF_EN adds stall/flush performance
// counters as extra output ports.
module pipe_ctrl #(
   parameter int STALL_W      = 6,
   parameter int MAX_EX_STALL = 64,
   parameter int CNT_W        = 8,
   parameter int PC_W         = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_id,
   input  logic               stallreq_ex,
   input  logic               flush_req,
   input  logic [PC_W-1:0]    flush_pc_i,
   input  logic               wd_clr,
   output logic [STALL_W-1:0] stall_o,
   output logic               flush_o,
   output logic [PC_W-1:0]    flush_pc_o,
   output logic               busy_o,
   output logic               stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]        perf_stall_cnt_o,
   output logic [15:0]        perf_flush_cnt_o
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      ID_STALL = 2'd1,
      EX_STALL = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   // EX stall holds PC, IF/ID, ID/EX and EX/MEM; ID stall holds PC, IF/ID, ID/EX.
   localparam logic [STALL_W-1:0] STALL_NONE = '0;
   localparam logic [STALL_W-1:0] STALL_EX   = STALL_W'(6'b001111);
   localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(6'b000111);
   localparam logic [CNT_W-1:0]   MAX_CNT    = CNT_W'(MAX_EX_STALL);

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   ex_cnt;
   logic               flush_take;
   logic               flush_active;
   logic               ex_inc;
   logic               wd_set;

   // A flush request is only honoured outside the FLUSH cycle.
   assign flush_take   = flush_req && (state != FLUSH);
   // Any flush in progress or being accepted kills EX-stall accounting.
   assign flush_active = flush_req || (state == FLUSH);
   assign ex_inc       = stallreq_ex && !flush_active;
   // The flag is raised only on the edge the counter first reaches the limit.
   assign wd_set       = ex_inc && (ex_cnt == MAX_CNT - CNT_W'(1));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples pre-edge values regardless of process order.
         state <= state_next;
      end
   end

   // Next-state decode: flush > EX stall > ID stall; FLUSH lasts one cycle.
   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = RUN;
      if (state == FLUSH) begin
         state_next = RUN;
      end else if (flush_req) begin
         state_next = FLUSH;
      end else if (stallreq_ex) begin
         state_next = EX_STALL;
      end else if (stallreq_id) begin
         state_next = ID_STALL;
      end
   end

   // Outputs: stall vector is combinational from inputs for 0-cycle latency.
   always_comb begin
      stall_o = STALL_NONE;
      busy_o  = (state != RUN);
      flush_o = (state == FLUSH);
      if (!rst || state == FLUSH || flush_req) begin
         stall_o = STALL_NONE;
      end else if (stallreq_ex) begin
         stall_o = STALL_EX;
      end else if (stallreq_id) begin
         stall_o = STALL_ID;
      end
   end

   // Redirect PC captured when a flush is accepted; held otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_pc_o <= '0;
      end else if (flush_take) begin
         flush_pc_o <= flush_pc_i;
      end
   end

   // Consecutive EX-stall cycle counter, saturating at the watchdog limit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_cnt <= '0;
      end else if (!ex_inc) begin
         ex_cnt <= '0;
      end else if (ex_cnt != MAX_CNT) begin
         ex_cnt <= ex_cnt + CNT_W'(1);
      end
   end

   // Sticky watchdog flag; a coincident set beats the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_timeout_o <= 1'b0;
      end else if (wd_set) begin
         stall_timeout_o <= 1'b1;
      end else if (wd_clr) begin
         stall_timeout_o <= 1'b0;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   // Free-running performance counters, wrapping at their width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cnt_o <= '0;
         perf_flush_cnt_o <= '0;
      end else begin
         if (stall_o != STALL_NONE) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
         end
         if (flush_o) begin
            perf_flush_cnt_o <= perf_flush_cnt_o + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Two instances share stimulus: dut uses the default watchdog limit,
// dut_wd uses a limit of 4 so the watchdog can be exercised quickly.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        flush_req;
   logic [31:0] flush_pc_i;
   logic        wd_clr;

   logic [5:0]  stall_o;
   logic        flush_o;
   logic [31:0] flush_pc_o;
   logic        busy_o;
   logic        stall_timeout_o;

   logic [5:0]  wd_stall_o;
   logic        wd_flush_o;
   logic [31:0] wd_flush_pc_o;
   logic        wd_busy_o;
   logic        wd_stall_timeout_o;

   int tests_run;
   int tests_failed;

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_ID   = 6'b000111;
   localparam logic [5:0] S_EX   = 6'b001111;

   pipe_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .stallreq_id     (stallreq_id),
      .stallreq_ex     (stallreq_ex),
      .flush_req       (flush_req),
      .flush_pc_i      (flush_pc_i),
      .wd_clr          (wd_clr),
      .stall_o         (stall_o),
      .flush_o         (flush_o),
      .flush_pc_o      (flush_pc_o),
      .busy_o          (busy_o),
      .stall_timeout_o (stall_timeout_o)
   );

   pipe_ctrl #(.MAX_EX_STALL(4)) dut_wd (
      .clk             (clk),
      .rst             (rst),
      .stallreq_id     (stallreq_id),
      .stallreq_ex     (stallreq_ex),
      .flush_req       (flush_req),
      .flush_pc_i      (flush_pc_i),
      .wd_clr          (wd_clr),
      .stall_o         (wd_stall_o),
      .flush_o         (wd_flush_o),
      .flush_pc_o      (wd_flush_pc_o),
      .busy_o          (wd_busy_o),
      .stall_timeout_o (wd_stall_timeout_o)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge, apply inputs, let comb logic settle.
   task automatic drive(input logic id, input logic ex, input logic fl,
                        input logic [31:0] pc, input logic clr);
      @(negedge clk);
      stallreq_id = id;
      stallreq_ex = ex;
      flush_req   = fl;
      flush_pc_i  = pc;
      wd_clr      = clr;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      stallreq_id  = 1'b0;
      stallreq_ex  = 1'b0;
      flush_req    = 1'b0;
      flush_pc_i   = 32'h0;
      wd_clr       = 1'b0;

      // ---- Reset with requests active ----
      #2;
      rst         = 1'b0;
      stallreq_ex = 1'b1;
      flush_req   = 1'b1;
      stallreq_id = 1'b1;
      flush_pc_i  = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stall",   32'(stall_o), 32'(S_NONE));
      check("rst_flush",   32'(flush_o), 32'd0);
      check("rst_pc",      flush_pc_o,   32'd0);
      check("rst_busy",    32'(busy_o),  32'd0);
      check("rst_timeout", 32'(stall_timeout_o), 32'd0);
      check("rst_excnt",   32'(dut.ex_cnt), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_busy",  32'(busy_o),  32'd0);
      check("post_rst_stall", 32'(stall_o), 32'(S_NONE));

      // ---- ID hazard, single cycle ----
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("id_stall_same_cycle", 32'(stall_o), 32'(S_ID));
      check("id_busy_same_cycle",  32'(busy_o),  32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("id_busy_next",  32'(busy_o),  32'd1);
      check("id_stall_next", 32'(stall_o), 32'(S_NONE));
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("id_busy_done",  32'(busy_o),  32'd0);

      // ---- EX multi-cycle with concurrent ID request: EX wins ----
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
         check($sformatf("ex_stall_%0d", i), 32'(stall_o), 32'(S_EX));
         check($sformatf("ex_cnt_%0d", i),   32'(dut.ex_cnt), i);
      end
      check("ex_busy", 32'(busy_o), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("ex_release_stall", 32'(stall_o), 32'(S_NONE));
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("ex_cnt_cleared", 32'(dut.ex_cnt), 32'd0);
      check("ex_no_timeout",  32'(stall_timeout_o), 32'd0);
      check("ex_busy_done",   32'(busy_o), 32'd0);

      // ---- Flush over an active EX stall ----
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check("fos_pre_stall", 32'(stall_o), 32'(S_EX));
      drive(1'b0, 1'b1, 1'b1, 32'hBFC0_0380, 1'b0);
      check("fos_req_stall", 32'(stall_o), 32'(S_NONE));
      check("fos_req_flush", 32'(flush_o), 32'd0);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check("fos_flush_o",  32'(flush_o), 32'd1);
      check("fos_flush_pc", flush_pc_o,   32'hBFC0_0380);
      check("fos_stall_in_flush", 32'(stall_o), 32'(S_NONE));
      check("fos_busy_in_flush",  32'(busy_o),  32'd1);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check("fos_flush_drop", 32'(flush_o), 32'd0);
      check("fos_stall_back", 32'(stall_o), 32'(S_EX));
      check("fos_pc_hold",    flush_pc_o,   32'hBFC0_0380);
      check("fos_cnt_after_flush", 32'(dut.ex_cnt), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      // ---- Back-to-back flush requests: second is dropped ----
      drive(1'b0, 1'b0, 1'b1, 32'h8000_0180, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      check("b2b_flush_first", 32'(flush_o), 32'd1);
      check("b2b_pc_first",    flush_pc_o,   32'h8000_0180);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("b2b_flush_second", 32'(flush_o), 32'd0);
      check("b2b_pc_held",      flush_pc_o,   32'h8000_0180);
      check("b2b_busy",         32'(busy_o),  32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("b2b_flush_quiet",  32'(flush_o), 32'd0);

      // ---- Watchdog on the limit-4 instance ----
      do_reset();
      check("wd_reset_flag", 32'(wd_stall_timeout_o), 32'd0);
      for (int k = 1; k <= 6; k++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
         @(posedge clk);
         #1;
         check($sformatf("wd_flag_edge%0d", k), 32'(wd_stall_timeout_o),
               (k >= 4) ? 32'd1 : 32'd0);
      end
      check("wd_cnt_saturated", 32'(dut_wd.ex_cnt), 32'd4);
      check("wd_default_quiet", 32'(stall_timeout_o), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      check("wd_flag_sticky", 32'(wd_stall_timeout_o), 32'd1);
      check("wd_cnt_released", 32'(dut_wd.ex_cnt), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      @(posedge clk);
      #1;
      check("wd_flag_cleared", 32'(wd_stall_timeout_o), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      // ---- Set beats a coincident clear ----
      for (int k = 1; k <= 3; k++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      end
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      @(posedge clk);
      #1;
      check("wd_set_beats_clr", 32'(wd_stall_timeout_o), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      // ---- Reset mid-stall returns everything to idle ----
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_mid_stall_o",  32'(stall_o), 32'(S_NONE));
      check("rst_mid_busy",     32'(busy_o),  32'd0);
      check("rst_mid_wd_flag",  32'(wd_stall_timeout_o), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Safety net so the run can never hang.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS32 flow CPU (PC, IF, ID, EX, MEM, WB).
- Collects stall requests from the ID stage (load-use hazard, single cycle per request) and the EX stage (multi-cycle ops).
- Collects flush requests (exception/redirect) and drives a per-stage stall vector, a registered flush pulse with redirect PC, and a watchdog on runaway EX stalls.
- Sits beside the pipeline registers; every pipeline register samples its stall bit and flush.

Parameters:
- STALL_W, 6, stall vector width; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- MAX_EX_STALL, 64, consecutive EX-stall cycles before the watchdog fires; legal range 1 to 2^CNT_W-1.
- CNT_W, 8, width of the EX-stall cycle counter.
- PC_W, 32, width of the redirect PC.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- stallreq_id  in  1  ID hazard stall request
- stallreq_ex  in  1  EX multi-cycle stall request
- flush_req  in  1  flush request, single-cycle pulse
- flush_pc_i  in  PC_W  redirect target, valid with flush_req
- wd_clr  in  1  clears sticky watchdog flag
- stall_o  out  STALL_W  per-stage hold vector
- flush_o  out  1  registered flush pulse to all pipeline registers
- flush_pc_o  out  PC_W  redirect PC, valid while flush_o=1
- busy_o  out  1  FSM not in RUN
- stall_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async): state=RUN; stall_o=0; flush_o=0; flush_pc_o=0; busy_o=0; stall_timeout_o=0; ex_cnt=0. Reset asserted mid-stall or mid-flush returns immediately to these values.
- FSM states: RUN, ID_STALL, EX_STALL, FLUSH. State is registered; stall_o is combinational from the current inputs and the current state, giving 0-cycle stall latency.
- Priority is flush_req > stallreq_ex > stallreq_id.
- stall_o decode:
  - state==FLUSH: 000000 (the flush wins and pipeline registers clear).
  - Otherwise, if flush_req=1: 000000.
  - Otherwise, if stallreq_ex=1: 001111.
  - Otherwise, if stallreq_id=1: 000111.
  - Otherwise: 000000.
- Transitions, evaluated from any non-FLUSH state:
  - flush_req=1 -> FLUSH.
  - else stallreq_ex=1 -> EX_STALL.
  - else stallreq_id=1 -> ID_STALL.
  - else -> RUN.
- FLUSH always returns to RUN after exactly 1 cycle. Requests arriving during the FLUSH cycle are ignored; requesters must re-assert.
- Flush latency is 1 cycle:
  - flush_req sampled at edge N; flush_o=1 and flush_pc_o=flush_pc_i(N) during cycle N+1.
  - flush_o is never high for 2 consecutive cycles.
  - flush_pc_o holds its last value otherwise.
- busy_o = (state != RUN).
- ex_cnt:
  - Increments on each edge where stallreq_ex=1 and no flush is active; saturates at MAX_EX_STALL.
  - Resets to 0 on any edge where stallreq_ex=0 or a flush occurs.
- Watchdog: stall_timeout_o is set on the edge where ex_cnt reaches MAX_EX_STALL. It stays set until wd_clr=1 or reset. If wd_clr and the set condition coincide, set wins.
- Simultaneous stallreq_id and stallreq_ex: EX wins (001111), state EX_STALL.
- Back-to-back flush_req pulses on consecutive cycles: the second falls in the FLUSH state and is dropped.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: add output ports perf_stall_cnt_o (32) and perf_flush_cnt_o (16).
  - perf_stall_cnt_o increments on each cycle where stall_o != 0.
  - perf_flush_cnt_o increments on each cycle where flush_o=1.
  - Both counters wrap modulo 2^width and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=0 while stallreq_ex=1 and flush_req=1 -> all outputs 0. rst released -> state RUN, stall_o=0.
- ID hazard: stallreq_id=1 for 1 cycle -> stall_o=000111 in the same cycle, busy_o=1 the next cycle, then 000000 and busy_o=0.
- EX multi-cycle:
  - stallreq_ex=1 for 10 cycles with stallreq_id=1 concurrently -> stall_o=001111 for all 10 cycles; ex_cnt returns to 0 after release; stall_timeout_o=0.
- Flush over stall:
  - stallreq_ex=1 held; flush_req=1 with flush_pc_i=32'hBFC00380 -> stall_o=0 that cycle; next cycle flush_o=1, flush_pc_o=32'hBFC00380, stall_o=0.
  - Following cycle: flush_o=0 and stall_o returns to 001111.
- Back-to-back flush: flush_req pulses in cycles N and N+1 -> exactly one flush_o pulse (cycle N+1).
- Watchdog: MAX_EX_STALL=4, stallreq_ex held 6 cycles -> stall_timeout_o=1 from the 4th edge onward and stays 1 after release. wd_clr=1 -> flag cleared.
